// File: rtl/mc_ramp_pwm_pkg.sv
// Shared types and clock-count derivations for the motor-controller ramp/PWM blocks.
package mc_ramp_pwm_pkg;

  // RUN   | tracking desired (ramped or direct), ESTOP forces neutral
  // DWELL | parked at neutral after a direction reversal
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DWELL = 1'b1
  } ch_state_e;

  function automatic int unsigned clk_per_us(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int unsigned frame_clk(input int unsigned clk_hz, input int unsigned frame_us);
    return frame_us * clk_per_us(clk_hz);
  endfunction

  function automatic int unsigned pulse_min_clk(input int unsigned clk_hz, input int unsigned min_us);
    return min_us * clk_per_us(clk_hz);
  endfunction

  function automatic int unsigned pulse_step_clk(input int unsigned clk_hz, input int unsigned min_us,
                                                 input int unsigned max_us, input int unsigned cmd_w);
    return ((max_us - min_us) * clk_per_us(clk_hz)) / ((32'd1 << cmd_w) - 32'd1);
  endfunction

  function automatic int unsigned neutral(input int unsigned cmd_w);
    return 32'd1 << (cmd_w - 1);
  endfunction

endpackage

// File: rtl/mc_ramp_pwm_channel.sv
// One motor channel: per-frame ramp toward the sampled command, reversal dwell at
// neutral, and the registered pulse comparator against the shared frame count.
module mc_ramp_pwm_channel
  import mc_ramp_pwm_pkg::*;
#(
  parameter int          CMD_W        = 5,
  parameter int          STEP         = 1,
  parameter int          DWELL_FRAMES = 5,
  parameter int unsigned MIN_CLK      = 50_000,
  parameter int unsigned STEP_CLK     = 1612,
  parameter int          CNT_W        = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             strobe_i,
  input  logic             estop_i,
  input  logic             ramp_en_i,
  input  logic [CMD_W-1:0] desired_i,
  output logic [CMD_W-1:0] current_o,
  output logic             at_target_o,
  output logic             pwm_o
);

  localparam int EXT_W = CMD_W + 1;
  localparam int DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [EXT_W-1:0] NEUTRAL_X = EXT_W'(neutral(CMD_W));
  localparam logic [EXT_W-1:0] STEP_X    = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] MAX_X     = EXT_W'((1 << CMD_W) - 1);
  localparam logic [CMD_W-1:0] NEUTRAL_C = CMD_W'(neutral(CMD_W));
  localparam logic [DW_W-1:0]  DW_INIT   = DW_W'(DWELL_FRAMES - 1);

  ch_state_e        state_q, state_d;
  logic [CMD_W-1:0] current_q, current_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             at_target_q, at_target_d;
  logic             pwm_q, pwm_d;

  logic [EXT_W-1:0] cur_x, des_x, tgt_x, diff_x, mv_x, ramp_x;
  logic [CMD_W-1:0] ramp_c;
  logic             reversal, reach_neutral;
  logic [31:0]      pulse_clk;

  assign cur_x    = {1'b0, current_q};
  assign des_x    = {1'b0, desired_i};
  assign reversal = ((des_x > NEUTRAL_X) && (cur_x < NEUTRAL_X)) ||
                    ((des_x < NEUTRAL_X) && (cur_x > NEUTRAL_X));
  assign tgt_x    = reversal ? NEUTRAL_X : des_x;
  assign diff_x   = (tgt_x >= cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);
  assign mv_x     = (diff_x < STEP_X) ? diff_x : STEP_X;
  assign ramp_x   = !ramp_en_i       ? tgt_x :
                    (tgt_x >= cur_x) ? (cur_x + mv_x) : (cur_x - mv_x);
  assign ramp_c   = (ramp_x > MAX_X) ? MAX_X[CMD_W-1:0] : ramp_x[CMD_W-1:0];
  assign reach_neutral = reversal && (ramp_c == NEUTRAL_C);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      current_q   <= NEUTRAL_C;
      dwell_q     <= '0;
      at_target_q <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      current_q   <= current_d;
      dwell_q     <= dwell_d;
      at_target_q <= at_target_d;
      pwm_q       <= pwm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (strobe_i) begin
      unique case (state_q)
        ST_RUN:   if (!estop_i && reach_neutral && (DWELL_FRAMES > 0)) state_d = ST_DWELL;
        ST_DWELL: if (estop_i || (dwell_q == '0)) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    current_d   = current_q;
    dwell_d     = dwell_q;
    at_target_d = at_target_q;
    if (strobe_i) begin
      if (estop_i) begin
        current_d = NEUTRAL_C;
        dwell_d   = '0;
      end else if (state_q == ST_DWELL) begin
        current_d = NEUTRAL_C;
        dwell_d   = (dwell_q == '0) ? '0 : (dwell_q - DW_W'(1));
      end else begin
        current_d = ramp_c;
        if (state_d == ST_DWELL) dwell_d = DW_INIT;
      end
      at_target_d = (current_d == desired_i) && (state_d == ST_RUN);
    end
  end

  // Compare lags the count by one cycle, so the pulse spans counts 1..width
  // and a CURRENT change at the strobe lands cleanly on the frame boundary.
  assign pulse_clk = MIN_CLK + 32'(current_q) * STEP_CLK;
  assign pwm_d     = 32'(count_i) < pulse_clk;

  assign current_o   = current_q;
  assign at_target_o = at_target_q;
  assign pwm_o       = pwm_q;

endmodule

// File: rtl/mc_ramp_pwm.sv
// N-channel ramped R/C-style pulse generator: shared frame counter and strobe,
// with one ramp/dwell channel per motor.
module mc_ramp_pwm
  import mc_ramp_pwm_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int CMD_W        = 5,
  parameter int CLK_HZ       = 50_000_000,
  parameter int FRAME_US     = 20000,
  parameter int PULSE_MIN_US = 1000,
  parameter int PULSE_MAX_US = 2000,
  parameter int STEP         = 1,
  parameter int DWELL_FRAMES = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH*CMD_W-1:0]   desired_i,
  input  logic                    estop_i,
  input  logic                    ramp_en_i,
  output logic [N_CH-1:0]         pwm_o,
  output logic [N_CH*CMD_W-1:0]   current_o,
  output logic [N_CH-1:0]         at_target_o,
  output logic                    frame_strobe_o
);

  localparam int unsigned FRAME_CLK = frame_clk(CLK_HZ, FRAME_US);
  localparam int unsigned MIN_CLK   = pulse_min_clk(CLK_HZ, PULSE_MIN_US);
  localparam int unsigned STEP_CLK  = pulse_step_clk(CLK_HZ, PULSE_MIN_US, PULSE_MAX_US, CMD_W);
  localparam int          CNT_W     = (FRAME_CLK > 1) ? $clog2(FRAME_CLK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLK - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             strobe;

  assign strobe  = (count_q == LAST);
  assign count_d = strobe ? '0 : (count_q + CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign frame_strobe_o = strobe;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mc_ramp_pwm_channel #(
      .CMD_W        (CMD_W),
      .STEP         (STEP),
      .DWELL_FRAMES (DWELL_FRAMES),
      .MIN_CLK      (MIN_CLK),
      .STEP_CLK     (STEP_CLK),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .count_i     (count_q),
      .strobe_i    (strobe),
      .estop_i     (estop_i),
      .ramp_en_i   (ramp_en_i),
      .desired_i   (desired_i[g*CMD_W +: CMD_W]),
      .current_o   (current_o[g*CMD_W +: CMD_W]),
      .at_target_o (at_target_o[g]),
      .pwm_o       (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_mc_ramp_pwm.sv
// Directed bench for mc_ramp_pwm: per-cycle comparison against a frame-level model
// plus literal checks of pulse widths and ramp/dwell sequences.
module tb_mc_ramp_pwm;

  localparam int N_CH         = 2;
  localparam int CMD_W        = 5;
  localparam int NEUTRAL      = 16;
  localparam int STEP         = 1;
  localparam int DWELL_FRAMES = 5;
  // Short frames keep the run compact; pulse timing is unchanged (1 clk per us).
  localparam int FRAME_US     = 2000;
  localparam int FRAME_CLK    = 2000;
  localparam int MIN_CLK      = 1000;
  localparam int STEP_CLK     = 32;

  logic                  clk;
  logic                  rst;
  logic [N_CH*CMD_W-1:0] desired;
  logic                  estop;
  logic                  ramp_en;
  logic [N_CH-1:0]       pwm;
  logic [N_CH*CMD_W-1:0] current;
  logic [N_CH-1:0]       at_target;
  logic                  frame_strobe;

  mc_ramp_pwm #(
    .N_CH         (N_CH),
    .CMD_W        (CMD_W),
    .CLK_HZ       (1_000_000),
    .FRAME_US     (FRAME_US),
    .PULSE_MIN_US (1000),
    .PULSE_MAX_US (2000),
    .STEP         (STEP),
    .DWELL_FRAMES (DWELL_FRAMES)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .desired_i      (desired),
    .estop_i        (estop),
    .ramp_en_i      (ramp_en),
    .pwm_o          (pwm),
    .current_o      (current),
    .at_target_o    (at_target),
    .frame_strobe_o (frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: one update per strobe; hold counts remaining dwell frames.
  typedef struct packed {
    int cur;
    int hold;
  } mch_t;

  mch_t m_ch  [N_CH];
  int   m_des [N_CH];
  int   m_cnt   = 0;
  bit   m_valid = 1'b0;

  function automatic mch_t mstep(input mch_t s, input int des, input bit es, input bit re);
    mch_t n;
    bit   rev;
    int   tgt;
    n = s;
    if (es) begin
      n.cur  = NEUTRAL;
      n.hold = 0;
    end else if (s.hold > 0) begin
      n.hold = s.hold - 1;
    end else begin
      rev = ((des > NEUTRAL) && (s.cur < NEUTRAL)) || ((des < NEUTRAL) && (s.cur > NEUTRAL));
      tgt = rev ? NEUTRAL : des;
      if (!re)              n.cur = tgt;
      else if (tgt > s.cur) n.cur = (tgt - s.cur > STEP) ? s.cur + STEP : tgt;
      else                  n.cur = (s.cur - tgt > STEP) ? s.cur - STEP : tgt;
      if (rev && (n.cur == NEUTRAL)) n.hold = DWELL_FRAMES;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        m_ch[c]  <= '{cur: NEUTRAL, hold: 0};
        m_des[c] <= 0;
      end
    end else if (m_cnt == FRAME_CLK - 1) begin
      m_cnt   <= 0;
      m_valid <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        m_ch[c]  <= mstep(m_ch[c], int'(desired[c*CMD_W +: CMD_W]), estop, ramp_en);
        m_des[c] <= int'(desired[c*CMD_W +: CMD_W]);
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  logic [N_CH*CMD_W-1:0] exp_cur;
  logic [N_CH-1:0]       exp_pwm;
  logic [N_CH-1:0]       exp_at;
  logic                  exp_stb;

  always_comb begin
    exp_cur = '0;
    exp_pwm = '0;
    exp_at  = '0;
    for (int c = 0; c < N_CH; c++) begin
      exp_cur[c*CMD_W +: CMD_W] = CMD_W'(m_ch[c].cur);
      exp_pwm[c] = (m_cnt >= 1) && (m_cnt - 1 < MIN_CLK + m_ch[c].cur * STEP_CLK);
      exp_at[c]  = m_valid && (m_ch[c].cur == m_des[c]) && (m_ch[c].hold == 0);
    end
  end
  assign exp_stb = (m_cnt == FRAME_CLK - 1);

  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", {current, at_target, pwm, frame_strobe},
                    {exp_cur, exp_at, exp_pwm, exp_stb});
  end

  // Runs up to and including the next strobe cycle; widths count PWM-high samples,
  // current/at_target are taken at the first cycle of the frame.
  task automatic run_frame(output int w0, output int w1, output int c0, output int c1, output int a);
    int n;
    bit seen;
    w0 = 0;
    w1 = 0;
    @(negedge clk);
    c0   = int'(current[0 +: CMD_W]);
    c1   = int'(current[CMD_W +: CMD_W]);
    a    = int'(at_target);
    w0  += int'(pwm[0]);
    w1  += int'(pwm[1]);
    seen = frame_strobe;
    n    = 1;
    while (!seen && (n < FRAME_CLK + 4)) begin
      @(negedge clk);
      w0  += int'(pwm[0]);
      w1  += int'(pwm[1]);
      seen = frame_strobe;
      n++;
    end
    chk("frame_strobe_seen", seen, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  int w0, w1, c0, c1, a;
  int exp1 [15] = '{19, 18, 17, 16, 16, 16, 16, 16, 16, 15, 14, 13, 12, 11, 10};

  initial begin
    rst     = 1'b1;
    estop   = 1'b0;
    ramp_en = 1'b1;
    desired = {5'd16, 5'd16};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_current", current, {5'd16, 5'd16});
    chk("rst_pwm", pwm, 0);
    chk("rst_at_target", at_target, 0);
    chk("rst_strobe", frame_strobe, 0);
    rst = 1'b0;

    run_frame(w0, w1, c0, c1, a);
    chk("f1_width0", w0, 1512);
    chk("f1_width1", w1, 1512);
    chk("f1_at", a, 0);
    run_frame(w0, w1, c0, c1, a);
    chk("f2_width0", w0, 1512);
    chk("f2_width1", w1, 1512);
    chk("f2_at", a, 3);

    ramp_en = 1'b0;
    desired[CMD_W +: CMD_W] = 5'd20;
    run_frame(w0, w1, c0, c1, a);
    chk("jump_cur1", c1, 20);
    chk("jump_cur0", c0, 16);
    chk("jump_at", a, 3);

    ramp_en = 1'b1;
    desired = {5'd10, 5'd24};
    for (int f = 0; f < 15; f++) begin
      run_frame(w0, w1, c0, c1, a);
      chk($sformatf("ramp_cur0_f%0d", f), c0, (f < 8) ? 17 + f : 24);
      chk($sformatf("rev_cur1_f%0d", f), c1, exp1[f]);
      chk($sformatf("rev_at1_f%0d", f), a[1], (f == 14) ? 1 : 0);
      if (f == 6) chk("ramp_at0_before", a[0], 0);
      if (f == 7) begin
        chk("ramp_at0_reached", a[0], 1);
        chk("ramp_width0_24", w0, 1768);
      end
      if (f == 5) chk("dwell_width1", w1, 1512);
    end
    chk("model_cur0_pin", m_ch[0].cur, 24);
    chk("model_cur1_pin", m_ch[1].cur, 10);

    ramp_en = 1'b0;
    desired[0 +: CMD_W] = 5'd31;
    run_frame(w0, w1, c0, c1, a);
    chk("direct_cur0", c0, 31);
    chk("direct_width0", w0, 1992);

    ramp_en = 1'b1;
    desired[0 +: CMD_W] = 5'd20;
    for (int f = 0; f < 3; f++) begin
      run_frame(w0, w1, c0, c1, a);
      chk($sformatf("down_cur0_f%0d", f), c0, 30 - f);
    end
    estop = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(w0, w1, c0, c1, a);
      chk($sformatf("estop_cur0_f%0d", f), c0, 16);
      chk($sformatf("estop_cur1_f%0d", f), c1, 16);
      chk($sformatf("estop_width0_f%0d", f), w0, 1512);
    end
    estop = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_frame(w0, w1, c0, c1, a);
      chk($sformatf("resume_cur0_f%0d", f), c0, 17 + f);
      chk($sformatf("resume_cur1_f%0d", f), c1, 15 - f);
    end

    ramp_en = 1'b0;
    desired[0 +: CMD_W] = 5'd31;
    repeat (701) @(negedge clk);
    chk("prerst_cur0", current[0 +: CMD_W], 31);
    chk("prerst_pwm0", pwm[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pwm", pwm, 0);
    chk("midrst_current", current, {5'd16, 5'd16});
    chk("midrst_at", at_target, 0);
    rst = 1'b0;
    run_frame(w0, w1, c0, c1, a);
    chk("postrst_width0", w0, 1512);
    chk("postrst_width1", w1, 1512);
    chk("postrst_cur0", c0, 16);
    run_frame(w0, w1, c0, c1, a);
    chk("final_cur0", c0, 31);
    chk("final_cur1", c1, 10);
    chk("final_width0", w0, 1992);
    chk("final_width1", w1, 1320);
    chk("final_at", a, 3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
